// File: rtl/sd_card_file_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_card_file_writer_if
//  Description : Board-RAM read port and SD block-write handshake bundle
//                shared by the file writer (master) and the RAM/SD side
//                (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface sd_card_file_writer_if;
    logic [23:0] address;
    logic        rden;
    logic        read_data;
    logic [31:0] blk_id;
    logic        blk_req;
    logic        blk_ack;
    logic [8:0]  blk_byte_idx;
    logic [7:0]  blk_byte;
    logic [15:0] blk_crc;

    modport master (
        output address, rden, blk_id, blk_req, blk_byte, blk_crc,
        input  read_data, blk_ack, blk_byte_idx
    );

    modport slave (
        input  address, rden, blk_id, blk_req, blk_byte, blk_crc,
        output read_data, blk_ack, blk_byte_idx
    );
endinterface
`default_nettype wire

// File: rtl/sd_card_file_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_card_file_writer
//  Description : Streams one board file out of the 1-bit board RAM, packs
//                each 4096-bit block into a buffer and hands it to the SD
//                block-write core over a 4-phase req/ack handshake.
//                Optional macro SD_WRITE_CRC_EN adds a CRC16-CCITT of each
//                buffered block on blk_crc (otherwise blk_crc is 0).
//  Revision    : 1.0  initial release
// ============================================================================
module sd_card_file_writer #(
    parameter int P_PARAM_W       = 800,
    parameter int P_PARAM_H       = 600,
    parameter int BLOCKS_PER_FILE = 128,
    parameter int RAM_RD_LAT      = 2
) (
    input  wire logic              clk_ram,
    input  wire logic              reset,
    input  wire logic [15:0]       file_id,
    input  wire logic              save_req,
    output logic                   save_busy,
    output logic                   save_done,
    sd_card_file_writer_if.master  bus
);

    localparam int BLK_W = $clog2(BLOCKS_PER_FILE);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Reject configurations the addressing scheme cannot represent.
    if (BLOCKS_PER_FILE < 2 || (1 << BLK_W) != BLOCKS_PER_FILE ||
        RAM_RD_LAT < 1 || RAM_RD_LAT > 4 ||
        P_PARAM_W * P_PARAM_H > BLOCKS_PER_FILE * 4096) begin : g_param_check
        $error("sd_card_file_writer: unsupported parameter set");
    end

    logic [2:0]                  state_q, state_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [23:0]                 address_q, address_d;
    logic                        rden_q, rden_d;
    logic [11:0]                 k_q, k_d;
    logic [31:0]                 blk_id_q, blk_id_d;
    logic                        blk_req_q, blk_req_d;
    logic                        ack_meta_q, ack_meta_d;
    logic                        ack_sync_q, ack_sync_d;
    logic [RAM_RD_LAT-1:0]       pv_q, pv_d;
    logic [RAM_RD_LAT-1:0][11:0] pk_q, pk_d;
    logic [4095:0]               buf_q, buf_d;

    logic        cap_en;
    logic [11:0] cap_k;

    // The last shadow stage lines up with read_data for the issued bit k.
    assign cap_en = pv_q[RAM_RD_LAT-1];
    assign cap_k  = pk_q[RAM_RD_LAT-1];

    // Control FSM: issue reads, wait for capture, then run the handshake.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        address_d = address_q;
        rden_d    = rden_q;
        k_d       = k_q;
        blk_id_d  = blk_id_q;
        blk_req_d = blk_req_q;
        case (state_q)
            S_IDLE: begin
                if (save_req) begin
                    busy_d    = 1'b1;
                    blk_id_d  = {16'b0, file_id} << BLK_W;
                    address_d = 24'd0;
                    k_d       = 12'd0;
                    rden_d    = 1'b1;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (rden_q) begin
                    address_d = address_q + 24'd1;
                    k_d       = k_q + 12'd1;
                    if (k_q == 12'hFFF) begin
                        rden_d = 1'b0;
                    end
                end
                if (cap_en && cap_k == 12'hFFF) begin
                    blk_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_sync_q) begin
                    blk_req_d = 1'b0;
                    state_d   = S_REL;
                end
            end
            S_REL: begin
                // A stuck-high ack parks here; no new fill until it drops.
                if (!ack_sync_q) begin
                    if (blk_id_q[BLK_W-1:0] == {BLK_W{1'b1}}) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        blk_id_d = blk_id_q + 32'd1;
                        k_d      = 12'd0;
                        rden_d   = 1'b1;
                        state_d  = S_FILL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read-latency shadow pipe of issued bit indices, plus ack synchroniser.
    always_comb begin
        pv_d[0] = rden_q;
        pk_d[0] = k_q;
        for (int i = 1; i < RAM_RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pk_d[i] = pk_q[i-1];
        end
        ack_meta_d = bus.blk_ack;
        ack_sync_d = ack_meta_q;
    end

    // Block buffer: bit k lands in byte k[11:3], bit k[2:0] (LSB first).
    always_comb begin
        buf_d = buf_q;
        if (cap_en) begin
            buf_d[cap_k] = bus.read_data;
        end
    end

    // Control and handshake state, cleared asynchronously.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            address_q  <= 24'd0;
            rden_q     <= 1'b0;
            k_q        <= 12'd0;
            blk_id_q   <= 32'd0;
            blk_req_q  <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            pv_q       <= '0;
            pk_q       <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            address_q  <= address_d;
            rden_q     <= rden_d;
            k_q        <= k_d;
            blk_id_q   <= blk_id_d;
            blk_req_q  <= blk_req_d;
            ack_meta_q <= ack_meta_d;
            ack_sync_q <= ack_sync_d;
            pv_q       <= pv_d;
            pk_q       <= pk_d;
        end
    end

    // Buffer storage needs no reset; every bit is rewritten before use.
    always_ff @(posedge clk_ram) begin
        buf_q <= buf_d;
    end

`ifdef SD_WRITE_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_byte_in;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Completed byte: bit 7 arriving now, bits 6..0 already in the buffer.
    assign crc_byte_in = {bus.read_data, buf_q[{cap_k[11:3], 3'd6} -: 7]};

    // CRC restarts with each block and folds in every byte as it completes.
    always_comb begin
        crc_d = crc_q;
        if (state_d == S_FILL && state_q != S_FILL) begin
            crc_d = 16'h0000;
        end else if (cap_en && cap_k[2:0] == 3'd7) begin
            crc_d = crc16_byte(crc_q, crc_byte_in);
        end
    end

    // CRC accumulator.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign bus.blk_crc = crc_q;
`else
    assign bus.blk_crc = 16'h0000;
`endif

    assign save_busy    = busy_q;
    assign save_done    = done_q;
    assign bus.address  = address_q;
    assign bus.rden     = rden_q;
    assign bus.blk_id   = blk_id_q;
    assign bus.blk_req  = blk_req_q;
    assign bus.blk_byte = buf_q[{bus.blk_byte_idx, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: tb/tb_sd_card_file_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_card_file_writer
//  Description : Directed self-checking bench for sd_card_file_writer with a
//                4-block file and a 4-cycle RAM read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sd_card_file_writer;

    localparam int TB_LAT    = 4;
    localparam int TB_BLOCKS = 4;
    localparam int LIMIT     = 6000;

    logic        clk_ram  = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] file_id  = 16'h0000;
    logic        save_req = 1'b0;
    logic        save_busy;
    logic        save_done;

    int checks   = 0;
    int failures = 0;
    int ram_mode = 0;

    int exp_addr = 0;
    int reads    = 0;
    int addr_err = 0;
    int done_cnt = 0;

    logic [TB_LAT-1:0] rd_pipe = '0;

    sd_card_file_writer_if bus();

    sd_card_file_writer #(
        .P_PARAM_W       (128),
        .P_PARAM_H       (128),
        .BLOCKS_PER_FILE (TB_BLOCKS),
        .RAM_RD_LAT      (TB_LAT)
    ) dut (
        .clk_ram   (clk_ram),
        .reset     (reset),
        .file_id   (file_id),
        .save_req  (save_req),
        .save_busy (save_busy),
        .save_done (save_done),
        .bus       (bus)
    );

    always #5 clk_ram = ~clk_ram;

    function automatic logic ram_bit(input int mode, input int n);
        case (mode)
            0:       return 1'b0;
            1:       return (n % 8) == 0;
            2:       return n == 4103;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int blk, input int idx);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j] = ram_bit(mode, blk * 4096 + idx * 8 + j);
        end
        return b;
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // RAM model: data for the presented address appears TB_LAT cycles later.
    always @(posedge clk_ram) begin
        rd_pipe <= {rd_pipe[TB_LAT-2:0], ram_bit(ram_mode, int'(bus.address))};
    end
    assign bus.read_data = rd_pipe[TB_LAT-1];

    // Read-address and done-pulse monitor, restarted by each accepted save.
    always @(negedge clk_ram) begin
        #1;
        if (reset || (save_req && !save_busy)) begin
            exp_addr = 0;
            reads    = 0;
            addr_err = 0;
            done_cnt = 0;
        end else begin
            if (bus.rden) begin
                if (int'(bus.address) != exp_addr) addr_err++;
                exp_addr++;
                reads++;
            end
            if (save_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_save(input logic [15:0] f);
        @(negedge clk_ram);
        file_id  = f;
        save_req = 1'b1;
        @(negedge clk_ram);
        save_req = 1'b0;
    endtask

    task automatic wait_req(output int cnt);
        cnt = 0;
        while (bus.blk_req !== 1'b1 && cnt < LIMIT) begin
            @(negedge clk_ram);
            cnt++;
        end
    endtask

    task automatic do_block(input logic [31:0] exp_id, input int blk, input int hold,
                            input int spot_idx, input logic [7:0] spot_val);
        int          cnt;
        int          bad;
        int          stall_bad;
        logic [15:0] crc;
        logic [7:0]  eb;
        wait_req(cnt);
        check("blk_req_rise", 32'(bus.blk_req), 32'd1);
        check("blk_id", bus.blk_id, exp_id);
        bad = 0;
        crc = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            bus.blk_byte_idx = 9'(i);
            #1;
            eb  = exp_byte(ram_mode, blk, i);
            crc = crc_byte(crc, eb);
            if (bus.blk_byte !== eb) bad++;
        end
        check("blk_byte_bad_count", 32'(bad), 32'd0);
        bus.blk_byte_idx = 9'(spot_idx);
        #1;
        check("blk_byte_spot", 32'(bus.blk_byte), 32'(spot_val));
`ifdef SD_WRITE_CRC_EN
        if (ram_mode == 3) crc = 16'h7FA1;
`else
        crc = 16'h0000;
`endif
        check("blk_crc", 32'(bus.blk_crc), 32'(crc));
        @(negedge clk_ram);
        bus.blk_ack = 1'b1;
        cnt = 0;
        while (bus.blk_req !== 1'b0 && cnt < 20) begin
            @(negedge clk_ram);
            cnt++;
        end
        check("blk_req_fall", 32'(bus.blk_req), 32'd0);
        stall_bad = 0;
        repeat (hold) begin
            @(negedge clk_ram);
            if (bus.rden !== 1'b0 || bus.blk_id !== exp_id) stall_bad++;
        end
        check("stall_while_ack_high", 32'(stall_bad), 32'd0);
        bus.blk_ack = 1'b0;
    endtask

    task automatic finish_save();
        int cnt;
        cnt = 0;
        while (save_done !== 1'b1 && cnt < 20) begin
            @(negedge clk_ram);
            cnt++;
        end
        check("save_done_pulse", 32'(save_done), 32'd1);
        check("busy_low_at_done", 32'(save_busy), 32'd0);
        repeat (3) @(negedge clk_ram);
        check("done_count", 32'(done_cnt), 32'd1);
        check("read_count", 32'(reads), 32'(TB_BLOCKS * 4096));
        check("addr_errors", 32'(addr_err), 32'd0);
    endtask

    initial begin
        int cnt;
        bus.blk_ack      = 1'b0;
        bus.blk_byte_idx = 9'd0;

        // Reset state.
        repeat (3) @(negedge clk_ram);
        check("rst_busy", 32'(save_busy), 32'd0);
        check("rst_done", 32'(save_done), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_rden", 32'(bus.rden), 32'd0);
        check("rst_blk_req", 32'(bus.blk_req), 32'd0);
        check("rst_blk_id", bus.blk_id, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_ram);
        check("idle_rden", 32'(bus.rden), 32'd0);

        // Save 1: bit n set when n%8==0, file 3 -> blocks 0xC..0xF.
        ram_mode = 1;
        start_save(16'd3);
        check("busy_after_req", 32'(save_busy), 32'd1);
        check("rden_after_req", 32'(bus.rden), 32'd1);
        check("first_address", 32'(bus.address), 32'd0);
        wait_req(cnt);
        check("fill_latency", 32'(cnt), 32'(4096 + TB_LAT));
        for (int b = 0; b < TB_BLOCKS; b++) begin
            do_block(32'h0000_000C + 32'(b), b, 2, 511, 8'h01);
        end
        finish_save();

        // Save 2: single set bit at 4103 -> block 1 byte 0 = 0x80.
        ram_mode = 2;
        start_save(16'h0ABC);
        do_block(32'h0000_2AF0, 0, 2, 0, 8'h00);
        do_block(32'h0000_2AF1, 1, 2, 0, 8'h80);
        do_block(32'h0000_2AF2, 2, 2, 0, 8'h00);
        do_block(32'h0000_2AF3, 3, 2, 0, 8'h00);
        finish_save();

        // Save 3: all ones, ack held 50 cycles, ignored save_req while busy.
        ram_mode = 3;
        start_save(16'd7);
        do_block(32'h0000_001C, 0, 50, 0, 8'hFF);
        repeat (100) @(negedge clk_ram);
        file_id  = 16'h0055;
        save_req = 1'b1;
        @(negedge clk_ram);
        save_req = 1'b0;
        do_block(32'h0000_001D, 1, 2, 100, 8'hFF);
        do_block(32'h0000_001E, 2, 2, 200, 8'hFF);
        do_block(32'h0000_001F, 3, 2, 300, 8'hFF);
        finish_save();

        // Save 4: reset asserted mid-fill of block 1.
        ram_mode = 0;
        start_save(16'd5);
        do_block(32'h0000_0014, 0, 2, 0, 8'h00);
        repeat (1500) @(negedge clk_ram);
        check("midfill_rden", 32'(bus.rden), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rden", 32'(bus.rden), 32'd0);
        check("async_rst_blk_req", 32'(bus.blk_req), 32'd0);
        check("async_rst_busy", 32'(save_busy), 32'd0);
        check("async_rst_address", 32'(bus.address), 32'd0);
        repeat (2) @(negedge clk_ram);
        reset = 1'b0;

        // Save 5: fresh save after reset restarts at the file base.
        ram_mode = 1;
        start_save(16'd6);
        check("restart_busy", 32'(save_busy), 32'd1);
        wait_req(cnt);
        check("restart_fill_latency", 32'(cnt), 32'(4096 + TB_LAT));
        do_block(32'h0000_0018, 0, 2, 3, 8'h01);
        check("restart_reads", 32'(reads), 32'd4096);
        check("restart_addr_errors", 32'(addr_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
